wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 208 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage. Selects the register-file write source
//               (ALU, load data, PC+4, upper immediate), aligns and extends
//               load data, and stalls upstream while a load result is
//               outstanding. Counts retired instructions and records sticky
//               load errors (timeout, misalignment, undefined load type).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_ip,
    input  logic [1:0]  wb_mux_ip,
    input  logic [31:0] alu_result_ip,
    input  logic        alu_result_valid_ip,
    input  logic [4:0]  write_reg_addr_ip,
    input  logic [31:0] pc_addr_ip,
    input  logic [31:0] uimmd_ip,
    input  logic [31:0] load_data_ip,
    input  logic        load_data_valid_ip,
    input  logic [2:0]  lsu_operator_ip,
    input  logic [1:0]  load_offset_ip,
    output logic        stall_op,
    output logic        rf_we_op,
    output logic [4:0]  rf_waddr_op,
    output logic [31:0] rf_wdata_op,
    output logic        load_err_op,
    output logic [31:0] retire_count_op
);

    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_SRC_ALU = 2'b00;
    localparam logic [1:0] c_SRC_LSU = 2'b01;
    localparam logic [1:0] c_SRC_PC4 = 2'b10;
    localparam logic [1:0] c_SRC_UIM = 2'b11;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_TW-1:0] r_tcount;
    logic [c_TW-1:0] w_tcount_nxt;

    // Details of a load that is waiting for its data word
    logic [4:0]      r_ld_waddr;
    logic [2:0]      r_ld_op;
    logic [1:0]      r_ld_off;

    logic            w_capture;
    logic            w_commit;
    logic            w_src_ok;
    logic            w_err;
    logic            w_timeout;
    logic            w_we;
    logic [4:0]      w_waddr;
    logic [31:0]     w_wdata;
    logic [2:0]      w_ld_op;
    logic [1:0]      w_ld_off;
    logic [32:0]     w_align;

    // Returns {error, aligned_data} for a load of type op at byte offset off
    function automatic logic [32:0] f_align(
        input logic [2:0]  op,
        input logic [1:0]  off,
        input logic [31:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [32:0] res;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h   = off[1] ? d[31:16] : d[15:0];
        res = {1'b1, 32'h0};
        case (op)
            3'b000:  res = {1'b0, {24{b[7]}}, b};
            3'b100:  res = {1'b0, 24'h0, b};
            3'b001:  res = off[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
            3'b101:  res = off[0] ? {1'b1, 32'h0} : {1'b0, 16'h0, h};
            3'b010:  res = (off == 2'd0) ? {1'b0, d} : {1'b1, 32'h0};
            default: res = {1'b1, 32'h0};
        endcase
        return res;
    endfunction

    // While waiting, the captured load attributes govern alignment
    assign w_ld_op  = (r_state == WAIT_LOAD) ? r_ld_op  : lsu_operator_ip;
    assign w_ld_off = (r_state == WAIT_LOAD) ? r_ld_off : load_offset_ip;
    assign w_align  = f_align(w_ld_op, w_ld_off, load_data_ip);
    assign stall_op = (r_state == WAIT_LOAD);

    // Next-state, timeout and write-back selection
    always_comb begin
        w_state_nxt  = r_state;
        w_tcount_nxt = r_tcount;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        w_src_ok     = 1'b1;
        w_err        = 1'b0;
        w_timeout    = 1'b0;
        w_waddr      = write_reg_addr_ip;
        w_wdata      = 32'h0;
        case (r_state)
            IDLE: begin
                if (valid_ip) begin
                    case (wb_mux_ip)
                        c_SRC_ALU: begin
                            w_commit = 1'b1;
                            w_src_ok = alu_result_valid_ip;
                            w_wdata  = alu_result_ip;
                        end
                        c_SRC_PC4: begin
                            w_commit = 1'b1;
                            w_wdata  = pc_addr_ip + 32'd4;
                        end
                        c_SRC_UIM: begin
                            w_commit = 1'b1;
                            w_wdata  = uimmd_ip;
                        end
                        default: begin
                            if (load_data_valid_ip) begin
                                w_commit = 1'b1;
                                w_err    = w_align[32];
                                w_wdata  = w_align[31:0];
                            end else begin
                                w_capture    = 1'b1;
                                w_state_nxt  = WAIT_LOAD;
                                w_tcount_nxt = '0;
                            end
                        end
                    endcase
                end
            end
            WAIT_LOAD: begin
                if (load_data_valid_ip) begin
                    w_commit    = 1'b1;
                    w_waddr     = r_ld_waddr;
                    w_err       = w_align[32];
                    w_wdata     = w_align[31:0];
                    w_state_nxt = IDLE;
                end else if (r_tcount == c_TLAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tcount_nxt = r_tcount + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_we = w_commit && w_src_ok && !w_err && (w_waddr != 5'd0);
    end

    // State register, timeout counter and pending-load capture
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tcount   <= '0;
            r_ld_waddr <= 5'd0;
            r_ld_op    <= 3'd0;
            r_ld_off   <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_tcount <= w_tcount_nxt;
            if (w_capture) begin
                r_ld_waddr <= write_reg_addr_ip;
                r_ld_op    <= lsu_operator_ip;
                r_ld_off   <= load_offset_ip;
            end
        end
    end

    // Register-file write port, retire counter and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we_op        <= 1'b0;
            rf_waddr_op     <= 5'd0;
            rf_wdata_op     <= 32'h0;
            load_err_op     <= 1'b0;
            retire_count_op <= 32'h0;
        end else begin
            rf_we_op <= w_we;
            if (w_we) begin
                rf_waddr_op <= w_waddr;
                rf_wdata_op <= w_wdata;
            end
            if (w_commit) begin
                retire_count_op <= retire_count_op + 32'd1;
            end
            if (w_err || w_timeout) begin
                load_err_op <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Directed self-checking bench for wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_ip;
    logic [1:0]  wb_mux_ip;
    logic [31:0] alu_result_ip;
    logic        alu_result_valid_ip;
    logic [4:0]  write_reg_addr_ip;
    logic [31:0] pc_addr_ip;
    logic [31:0] uimmd_ip;
    logic [31:0] load_data_ip;
    logic        load_data_valid_ip;
    logic [2:0]  lsu_operator_ip;
    logic [1:0]  load_offset_ip;
    logic        stall_op;
    logic        rf_we_op;
    logic [4:0]  rf_waddr_op;
    logic [31:0] rf_wdata_op;
    logic        load_err_op;
    logic [31:0] retire_count_op;

    int total = 0;
    int bad   = 0;

    wb_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clock               (clock),
        .reset               (reset),
        .valid_ip            (valid_ip),
        .wb_mux_ip           (wb_mux_ip),
        .alu_result_ip       (alu_result_ip),
        .alu_result_valid_ip (alu_result_valid_ip),
        .write_reg_addr_ip   (write_reg_addr_ip),
        .pc_addr_ip          (pc_addr_ip),
        .uimmd_ip            (uimmd_ip),
        .load_data_ip        (load_data_ip),
        .load_data_valid_ip  (load_data_valid_ip),
        .lsu_operator_ip     (lsu_operator_ip),
        .load_offset_ip      (load_offset_ip),
        .stall_op            (stall_op),
        .rf_we_op            (rf_we_op),
        .rf_waddr_op         (rf_waddr_op),
        .rf_wdata_op         (rf_wdata_op),
        .load_err_op         (load_err_op),
        .retire_count_op     (retire_count_op)
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; valid_ip = 1'b0; wb_mux_ip = 2'b00;
        alu_result_ip = '0; alu_result_valid_ip = 1'b0; write_reg_addr_ip = '0;
        pc_addr_ip = '0; uimmd_ip = '0; load_data_ip = '0; load_data_valid_ip = 1'b0;
        lsu_operator_ip = '0; load_offset_ip = '0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_stall", {31'd0, stall_op}, 32'd0);
        chk("rst_we",    {31'd0, rf_we_op}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr_op}, 32'd0);
        chk("rst_wdata", rf_wdata_op, 32'd0);
        chk("rst_err",   {31'd0, load_err_op}, 32'd0);
        chk("rst_count", retire_count_op, 32'd0);

        // ALU write
        valid_ip = 1'b1; wb_mux_ip = 2'b00; alu_result_ip = 32'h1234;
        alu_result_valid_ip = 1'b1; write_reg_addr_ip = 5'd5;
        cyc();
        valid_ip = 1'b0;
        chk("alu_we",    {31'd0, rf_we_op}, 32'd1);
        chk("alu_waddr", {27'd0, rf_waddr_op}, 32'd5);
        chk("alu_wdata", rf_wdata_op, 32'h1234);
        chk("alu_count", retire_count_op, 32'd1);
        cyc();
        chk("pulse_we",   {31'd0, rf_we_op}, 32'd0);
        chk("hold_waddr", {27'd0, rf_waddr_op}, 32'd5);
        chk("hold_wdata", rf_wdata_op, 32'h1234);

        // Loads with data immediately available
        valid_ip = 1'b1; wb_mux_ip = 2'b01; lsu_operator_ip = 3'b000; load_offset_ip = 2'd3;
        load_data_ip = 32'h80FF_FFFF; load_data_valid_ip = 1'b1; write_reg_addr_ip = 5'd6;
        cyc();
        chk("lb_wdata", rf_wdata_op, 32'hFFFF_FF80);
        chk("lb_we",    {31'd0, rf_we_op}, 32'd1);
        chk("lb_stall", {31'd0, stall_op}, 32'd0);
        chk("lb_count", retire_count_op, 32'd2);
        lsu_operator_ip = 3'b100; write_reg_addr_ip = 5'd7;
        cyc();
        chk("lbu_wdata", rf_wdata_op, 32'h0000_0080);
        chk("lbu_waddr", {27'd0, rf_waddr_op}, 32'd7);
        chk("lbu_count", retire_count_op, 32'd3);

        // Load waits two cycles for data; captured op/offset must be used
        lsu_operator_ip = 3'b101; load_offset_ip = 2'd2; load_data_valid_ip = 1'b0;
        write_reg_addr_ip = 5'd8;
        cyc();
        valid_ip = 1'b0;
        chk("wait_stall1", {31'd0, stall_op}, 32'd1);
        chk("wait_we1",    {31'd0, rf_we_op}, 32'd0);
        cyc();
        chk("wait_stall2", {31'd0, stall_op}, 32'd1);
        cyc();
        load_data_ip = 32'hAABB_CCDD; load_data_valid_ip = 1'b1;
        lsu_operator_ip = 3'b000; load_offset_ip = 2'd0;
        valid_ip = 1'b1; wb_mux_ip = 2'b00; write_reg_addr_ip = 5'd9;
        cyc();
        valid_ip = 1'b0; load_data_valid_ip = 1'b0;
        chk("wait_we",    {31'd0, rf_we_op}, 32'd1);
        chk("wait_waddr", {27'd0, rf_waddr_op}, 32'd8);
        chk("wait_wdata", rf_wdata_op, 32'h0000_AABB);
        chk("wait_stall", {31'd0, stall_op}, 32'd0);
        chk("wait_count", retire_count_op, 32'd4);
        cyc();
        chk("ignored_valid_count", retire_count_op, 32'd4);
        chk("ignored_valid_we",    {31'd0, rf_we_op}, 32'd0);

        // Timeout after 16 cycles with no data
        valid_ip = 1'b1; wb_mux_ip = 2'b01; lsu_operator_ip = 3'b010; load_offset_ip = 2'd0;
        write_reg_addr_ip = 5'd10;
        cyc();
        valid_ip = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_no_we", {31'd0, rf_we_op}, 32'd0);
            cyc();
        end
        chk("to_stall16", {31'd0, stall_op}, 32'd1);
        chk("to_err16",   {31'd0, load_err_op}, 32'd0);
        cyc();
        chk("to_stall", {31'd0, stall_op}, 32'd0);
        chk("to_err",   {31'd0, load_err_op}, 32'd1);
        chk("to_we",    {31'd0, rf_we_op}, 32'd0);
        chk("to_count", retire_count_op, 32'd4);

        // PC+4 to x0 suppressed, then PC+4 wrap to x1
        valid_ip = 1'b1; wb_mux_ip = 2'b10; pc_addr_ip = 32'hFFFF_FFFC; write_reg_addr_ip = 5'd0;
        cyc();
        chk("x0_we",    {31'd0, rf_we_op}, 32'd0);
        chk("x0_count", retire_count_op, 32'd5);
        chk("x0_hold",  {27'd0, rf_waddr_op}, 32'd8);
        write_reg_addr_ip = 5'd1;
        cyc();
        valid_ip = 1'b0;
        chk("wrap_we",    {31'd0, rf_we_op}, 32'd1);
        chk("wrap_wdata", rf_wdata_op, 32'h0000_0000);
        chk("wrap_count", retire_count_op, 32'd6);

        // Upper immediate
        valid_ip = 1'b1; wb_mux_ip = 2'b11; uimmd_ip = 32'h1234_5000; write_reg_addr_ip = 5'd11;
        cyc();
        valid_ip = 1'b0;
        chk("uimm_wdata", rf_wdata_op, 32'h1234_5000);
        chk("uimm_count", retire_count_op, 32'd7);

        // Reset during WAIT_LOAD, then data arrives
        valid_ip = 1'b1; wb_mux_ip = 2'b01; load_data_valid_ip = 1'b0; write_reg_addr_ip = 5'd4;
        cyc();
        valid_ip = 1'b0;
        chk("pre_rst_stall", {31'd0, stall_op}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0; load_data_ip = 32'h1234_5678; load_data_valid_ip = 1'b1;
        cyc();
        load_data_valid_ip = 1'b0;
        chk("mrst_stall", {31'd0, stall_op}, 32'd0);
        chk("mrst_we",    {31'd0, rf_we_op}, 32'd0);
        chk("mrst_waddr", {27'd0, rf_waddr_op}, 32'd0);
        chk("mrst_wdata", rf_wdata_op, 32'd0);
        chk("mrst_err",   {31'd0, load_err_op}, 32'd0);
        chk("mrst_count", retire_count_op, 32'd0);

        // Misaligned halfword: no write, error set, still retired
        valid_ip = 1'b1; wb_mux_ip = 2'b01; lsu_operator_ip = 3'b001; load_offset_ip = 2'd1;
        load_data_valid_ip = 1'b1; write_reg_addr_ip = 5'd3;
        cyc();
        chk("mis_we",    {31'd0, rf_we_op}, 32'd0);
        chk("mis_err",   {31'd0, load_err_op}, 32'd1);
        chk("mis_count", retire_count_op, 32'd1);

        // Aligned word and sign-extended halfword; error stays sticky
        lsu_operator_ip = 3'b010; load_offset_ip = 2'd0; load_data_ip = 32'hDEAD_BEEF;
        write_reg_addr_ip = 5'd2;
        cyc();
        chk("lw_wdata", rf_wdata_op, 32'hDEAD_BEEF);
        chk("lw_count", retire_count_op, 32'd2);
        chk("err_sticky", {31'd0, load_err_op}, 32'd1);
        lsu_operator_ip = 3'b001; load_offset_ip = 2'd0; write_reg_addr_ip = 5'd12;
        cyc();
        valid_ip = 1'b0; load_data_valid_ip = 1'b0;
        chk("lh_wdata", rf_wdata_op, 32'hFFFF_BEEF);
        chk("lh_count", retire_count_op, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
